cache_arbiter: RTL and testbench
================================

# cache_arbiter

Two-port arbiter that shares the single cache access port between an instruction-fetch requester (port 0) and a data requester (port 1). It selects one request at a time round-robin and drives the cache read/write strobes, addresses and write line. It holds them until the cache signals `ready`, then returns the line and hit status to the winner. Sits directly in front of `cache`, between the core and the cache/memory subsystem; also keeps hit/miss counters and a timeout watchdog.

## Interface
- `ADDR_W`, 32, address width.
- `LINE_W`, 1024, cache line width.
- `CNT_W`, 16, width of hit/miss counters (saturating).
- `TIMEOUT`, 64, max cycles waiting for `ready` before abort (≥2).

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_read`  in  [1:0]  per-port read request, level, held until `done`.
- `req_write`  in  [1:0]  per-port write request, level, held until `done`.
- `req_addr`  in  [1:0][ADDR_W-1:0]  per-port line address.
- `req_wdata`  in  [1:0][LINE_W-1:0]  per-port write line.
- `done`  out  [1:0]  one-cycle completion pulse to the winning port.
- `rsp_data`  out  LINE_W  line returned by last completed read; holds until next read completes.
- `rsp_hit`  out  1  hit status of last completed transaction.
- `rsp_err`  out  1  high with `done` when the transaction timed out.
- `read`, `write`  out  1  cache strobes.
- `load_address`, `write_address`  out  ADDR_W  cache addresses.
- `write_data`  out  LINE_W  cache write line.
- `load_data`  in  LINE_W  cache read line.
- `hit`, `ready`  in  1  cache status; sampled only on a `ready` edge.
- `hit_count`, `miss_count`  out  CNT_W  completed-transaction counters.
- `timeout_flag`  out  1  sticky; set on any timeout.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if any port requests, pick winner, latch its op/address/wdata, go ISSUE. Otherwise stay.
- ISSUE:
  - Drive `read` or `write` high with latched address/data, stable every cycle.
  - On edge with `ready`=1: capture `load_data` (reads only) into `rsp_data`, capture `hit` into `rsp_hit`, bump `hit_count` or `miss_count`, go RESP.
  - Wait counter reaching TIMEOUT-1 without `ready`: set `rsp_err`, set `timeout_flag`, counters unchanged, go RESP.
- RESP:
  - `read`/`write` low (mandatory one-cycle gap).
  - `done[winner]`=1 for exactly this cycle.
  - Arbitrate again: pending request → ISSUE directly; else → IDLE.
- Arbitration:
  - Round-robin; `last` pointer updated on each grant.
  - Both requesting: grant port ≠ `last`.
  - `last` resets to 1, so port 0 wins the first tie.
- Request with both `req_read` and `req_write` high: treated as write.
- Request inputs are latched at grant. Requester changes or drops after grant do not affect the in-flight transaction; `done` still pulses.
- Only the active strobe's address is meaningful. Both `load_address` and `write_address` are driven from the latched address.
- Counters saturate at all-ones.

## Timing
- Reset values:
  - State IDLE, `last`=1.
  - `read`, `write`, `done`, `rsp_hit`, `rsp_err`, `timeout_flag`: 0.
  - Addresses, `write_data`, `rsp_data`, counters: 0.
- All outputs are registered. Reset mid-transaction drops strobes immediately (async) with no `done`.
- Request seen at edge N → strobe high after N. With `ready` at edge N+k (k≥1), `done` is high during cycle after N+k. Minimum request-to-done is 2 edges.
- Back-to-back: strobe low exactly one cycle between transactions.
- Timeout: strobe high for exactly TIMEOUT cycles, then RESP with `rsp_err`=1.
- `rsp_err` clears on the next RESP without timeout.

## Structure
- Package `cache_arb_pkg`: state enum (IDLE/ISSUE/RESP), op enum (OP_READ/OP_WRITE), default parameter constants.
- One sub-module, `rr_arbiter2`: 2-requester round-robin picker with `last` pointer and grant output.

## Test plan
- Single port-0 read at addr 0; `ready` after 4 cycles, `load_data`=all-ones, `hit`=0 → `done[0]` one cycle, `rsp_data`=all-ones, `miss_count`=1.
- Both ports read simultaneously after reset (addr 0x0 / 0x40000000), `ready` 1 cycle each → port 0 served first, then port 1; one-cycle strobe gap; port 1 `load_address`=0x40000000.
- Port 1 write, `req_wdata`=1, `hit`=1 at `ready` → `write`=1, `write_data`=1, `done[1]`, `hit_count`=1, `rsp_data` unchanged.
- Port 0 held requesting continuously while port 1 requests → strict alternation 0,1,0,1 over 4 completions.
- `ready` never asserted, TIMEOUT=8 → strobe high 8 cycles, `done` with `rsp_err`=1, `timeout_flag`=1, counters unchanged.
- Assert `rst`=0 mid-ISSUE → strobes 0 immediately, no `done`, state IDLE; next request completes normally.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and default sizing for the cache port arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_LINE_W  = 1024;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker. On a tie the port that did not win
// last time is granted; 'last' only moves when the grant is consumed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_reg;

  // Combinational pick from the current requests and the last winner.
  always_comb begin
    gnt_valid = |req;
    if (&req) begin
      gnt_idx = ~last_reg;
    end else begin
      gnt_idx = req[1];
    end
  end

  // Remember the winner of every consumed grant; resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg <= 1'b1;
    end else if (en && gnt_valid) begin
      last_reg <= gnt_idx;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single cache access port between instruction fetch (port 0)
// and data (port 1). Requests are latched at grant, strobes are held until
// the cache answers with ready (or the watchdog expires), then the winner
// gets a one-cycle done pulse together with the line and hit status.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_read,
  input  logic [1:0]             req_write,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][LINE_W-1:0] req_wdata,
  output logic [1:0]             done,
  output logic [LINE_W-1:0]      rsp_data,
  output logic                   rsp_hit,
  output logic                   rsp_err,
  output logic                   read,
  output logic                   write,
  output logic [ADDR_W-1:0]      load_address,
  output logic [ADDR_W-1:0]      write_address,
  output logic [LINE_W-1:0]      write_data,
  input  logic [LINE_W-1:0]      load_data,
  input  logic                   hit,
  input  logic                   ready,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count,
  output logic                   timeout_flag
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  state_t              state_reg, state_next;
  op_t                 op_reg, op_next;
  logic                winner_reg, winner_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LINE_W-1:0]   wdata_reg, wdata_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic                read_reg, read_next;
  logic                write_reg, write_next;
  logic [1:0]          done_reg, done_next;
  logic [LINE_W-1:0]   rsp_data_reg, rsp_data_next;
  logic                rsp_hit_reg, rsp_hit_next;
  logic                rsp_err_reg, rsp_err_next;
  logic                tflag_reg, tflag_next;
  logic [CNT_W-1:0]    hit_cnt_reg, hit_cnt_next;
  logic [CNT_W-1:0]    miss_cnt_reg, miss_cnt_next;

  logic [1:0]          req_any;
  logic [1:0]          arb_req;
  logic                arb_en;
  logic                gnt_valid;
  logic                gnt_idx;
  logic                wait_expired;

  assign req_any = req_read | req_write;

  // The winner only sees done during RESP, so its request is still up on
  // that edge; mask it so a finished request is never re-granted.
  assign arb_req = (state_reg == RESP) ? (req_any & (winner_reg ? 2'b01 : 2'b10)) : req_any;
  assign arb_en  = (state_reg == IDLE) || (state_reg == RESP);

  // Counter reaches TIMEOUT-1 on the TIMEOUT-th strobe cycle.
  assign wait_expired = (wait_reg == WAIT_W'(TIMEOUT - 1));

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .en        (arb_en),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // State and all registered outputs; reset drops strobes immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      op_reg       <= OP_READ;
      winner_reg   <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wait_reg     <= '0;
      read_reg     <= 1'b0;
      write_reg    <= 1'b0;
      done_reg     <= 2'b00;
      rsp_data_reg <= '0;
      rsp_hit_reg  <= 1'b0;
      rsp_err_reg  <= 1'b0;
      tflag_reg    <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      winner_reg   <= winner_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      wait_reg     <= wait_next;
      read_reg     <= read_next;
      write_reg    <= write_next;
      done_reg     <= done_next;
      rsp_data_reg <= rsp_data_next;
      rsp_hit_reg  <= rsp_hit_next;
      rsp_err_reg  <= rsp_err_next;
      tflag_reg    <= tflag_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
    end
  end

  // Next-state: grant leaves IDLE/RESP, ready or watchdog leaves ISSUE.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (gnt_valid) state_next = ISSUE;
      ISSUE:   if (ready || wait_expired) state_next = RESP;
      RESP:    state_next = gnt_valid ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the latched request, strobes, response and counters.
  always_comb begin
    op_next       = op_reg;
    winner_next   = winner_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    wait_next     = wait_reg;
    read_next     = read_reg;
    write_next    = write_reg;
    done_next     = 2'b00;
    rsp_data_next = rsp_data_reg;
    rsp_hit_next  = rsp_hit_reg;
    rsp_err_next  = rsp_err_reg;
    tflag_next    = tflag_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    unique case (state_reg)
      IDLE, RESP: begin
        read_next  = 1'b0;
        write_next = 1'b0;
        if (gnt_valid) begin
          // Read+write together is a write.
          winner_next = gnt_idx;
          op_next     = req_write[gnt_idx] ? OP_WRITE : OP_READ;
          addr_next   = req_addr[gnt_idx];
          wdata_next  = req_wdata[gnt_idx];
          wait_next   = '0;
          read_next   = ~req_write[gnt_idx];
          write_next  = req_write[gnt_idx];
        end
      end
      ISSUE: begin
        if (ready) begin
          read_next              = 1'b0;
          write_next             = 1'b0;
          done_next[winner_reg]  = 1'b1;
          rsp_hit_next           = hit;
          rsp_err_next           = 1'b0;
          if (op_reg == OP_READ) rsp_data_next = load_data;
          if (hit) begin
            if (!(&hit_cnt_reg)) hit_cnt_next = hit_cnt_reg + CNT_W'(1);
          end else begin
            if (!(&miss_cnt_reg)) miss_cnt_next = miss_cnt_reg + CNT_W'(1);
          end
        end else if (wait_expired) begin
          // An aborted access never hit; counters stay untouched.
          read_next             = 1'b0;
          write_next            = 1'b0;
          done_next[winner_reg] = 1'b1;
          rsp_hit_next          = 1'b0;
          rsp_err_next          = 1'b1;
          tflag_next            = 1'b1;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign done          = done_reg;
  assign rsp_data      = rsp_data_reg;
  assign rsp_hit       = rsp_hit_reg;
  assign rsp_err       = rsp_err_reg;
  assign read          = read_reg;
  assign write         = write_reg;
  assign load_address  = addr_reg;
  assign write_address = addr_reg;
  assign write_data    = wdata_reg;
  assign hit_count     = hit_cnt_reg;
  assign miss_count    = miss_cnt_reg;
  assign timeout_flag  = tflag_reg;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: a cache responder with programmable
// latency, a scoreboard of expected completions, a vector table and a few
// hand-written multi-cycle sequences.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int CW = 16;
  localparam int TO = 8;

  localparam logic [LW-1:0] ONES  = '1;
  localparam logic [LW-1:0] PAT_A = {4{32'hA5A5_0001}};
  localparam logic [LW-1:0] PAT_B = {4{32'h3C3C_5A02}};
  localparam logic [LW-1:0] PAT_C = {4{32'h0F1E_2D03}};

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_read;
  logic [1:0]          req_write;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][LW-1:0]  req_wdata;
  logic [1:0]          done;
  logic [LW-1:0]       rsp_data;
  logic                rsp_hit;
  logic                rsp_err;
  logic                read;
  logic                write;
  logic [AW-1:0]       load_address;
  logic [AW-1:0]       write_address;
  logic [LW-1:0]       write_data;
  logic [LW-1:0]       load_data;
  logic                hit;
  logic                ready = 1'b0;
  logic [CW-1:0]       hit_count;
  logic [CW-1:0]       miss_count;
  logic                timeout_flag;

  always #5 clk = ~clk;

  cache_arbiter #(
    .ADDR_W  (AW),
    .LINE_W  (LW),
    .CNT_W   (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_read      (req_read),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .done          (done),
    .rsp_data      (rsp_data),
    .rsp_hit       (rsp_hit),
    .rsp_err       (rsp_err),
    .read          (read),
    .write         (write),
    .load_address  (load_address),
    .write_address (write_address),
    .write_data    (write_data),
    .load_data     (load_data),
    .hit           (hit),
    .ready         (ready),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .timeout_flag  (timeout_flag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- cache responder ----------------
  int            cfg_lat  = 0;     // 0: never ready
  bit            cfg_hit  = 1'b0;
  logic [LW-1:0] cfg_load = '0;
  int            run_cnt  = 0;
  int            gap_cnt  = 0;
  int            last_run = 0;
  int            last_gap = 0;
  logic [AW-1:0] run_addr = '0;
  bit            run_wr   = 1'b0;
  logic [LW-1:0] run_wdata = '0;
  bit            unstable = 1'b0;

  assign hit       = cfg_hit;
  assign load_data = cfg_load;

  // Measure strobe runs and gaps, check stability, raise ready after cfg_lat cycles.
  always @(negedge clk) begin
    if (read === 1'b1 || write === 1'b1) begin
      if (run_cnt == 0) begin
        last_gap  = gap_cnt;
        run_addr  = load_address;
        run_wr    = write;
        run_wdata = write_data;
        unstable  = (read === write) || (write_address !== load_address);
      end else if (load_address !== run_addr || write_address !== run_addr ||
                   write !== run_wr || read === write) begin
        unstable = 1'b1;
      end
      run_cnt++;
      gap_cnt = 0;
      ready = (cfg_lat != 0) && (run_cnt == cfg_lat);
    end else begin
      if (run_cnt != 0) last_run = run_cnt;
      run_cnt = 0;
      gap_cnt++;
      ready = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int            port;
    bit            err;
    bit            hit;
    logic [LW-1:0] data;
    int            hc;
    int            mc;
    bit            tflag;
  } exp_t;

  exp_t          sb[$];
  exp_t          cur;
  int            m_hit   = 0;
  int            m_miss  = 0;
  logic [LW-1:0] m_data  = '0;
  bit            m_tflag = 1'b0;
  logic [1:0]    done_prev = 2'b00;

  task automatic model_reset();
    m_hit   = 0;
    m_miss  = 0;
    m_data  = '0;
    m_tflag = 1'b0;
    sb.delete();
  endtask

  task automatic push_exp(input int port, input bit wr, input bit tmo, input bit hitv,
                          input logic [LW-1:0] load);
    exp_t e;
    if (tmo) begin
      m_tflag = 1'b1;
    end else begin
      if (hitv) m_hit++;
      else      m_miss++;
      if (!wr) m_data = load;
    end
    e.port  = port;
    e.err   = tmo;
    e.hit   = hitv;
    e.data  = m_data;
    e.hc    = m_hit;
    e.mc    = m_miss;
    e.tflag = m_tflag;
    sb.push_back(e);
  endtask

  // Pop one expectation per done pulse and compare the response.
  always @(negedge clk) begin
    if (done !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", LW'(done), '0);
      end else begin
        cur = sb.pop_front();
        chk("done_port", LW'(done), (cur.port == 1) ? LW'(2) : LW'(1));
        chk("done_pulse", LW'(done_prev), '0);
        chk("rsp_err", LW'(rsp_err), LW'(cur.err));
        if (!cur.err) chk("rsp_hit", LW'(rsp_hit), LW'(cur.hit));
        chk("rsp_data", rsp_data, cur.data);
        chk("hit_count", LW'(hit_count), LW'(cur.hc));
        chk("miss_count", LW'(miss_count), LW'(cur.mc));
        chk("timeout_flag", LW'(timeout_flag), LW'(cur.tflag));
        $display("done port %0d err %0d hit %0d hits %0d misses %0d", cur.port, rsp_err, rsp_hit,
                 hit_count, miss_count);
      end
    end
    done_prev = done;
  end

  // Wait for done on a port, optionally dropping its request; bounded.
  task automatic wait_done(input int p, input bit keep, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done[p] === 1'b1) begin
        if (!keep) begin
          req_read[p]  = 1'b0;
          req_write[p] = 1'b0;
        end
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_done: port %0d got no done, required within %0d cycles", p, budget);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            port;
    bit            wr;
    bit            both;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            lat;
    bit            hitv;
    logic [LW-1:0] load;
    bit            exp_wr;
    int            exp_strobe;
    bit            exp_err;
  } vec_t;

  function automatic vec_t mk(input int port, input bit wr, input bit both, input logic [AW-1:0] addr,
                              input logic [LW-1:0] wdata, input int lat, input bit hitv,
                              input logic [LW-1:0] load, input bit exp_wr, input int exp_strobe,
                              input bit exp_err);
    vec_t v;
    v.port = port; v.wr = wr; v.both = both; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.hitv = hitv; v.load = load;
    v.exp_wr = exp_wr; v.exp_strobe = exp_strobe; v.exp_err = exp_err;
    return v;
  endfunction

  localparam int NV = 7;
  vec_t vecs[NV];
  vec_t v;
  int   cyc;

  initial begin
    vecs[0] = mk(0, 1'b0, 1'b0, 32'h0000_0000, '0,     4, 1'b0, ONES,  1'b0, 4,  1'b0);
    vecs[1] = mk(1, 1'b1, 1'b0, 32'h0000_0080, LW'(1), 1, 1'b1, PAT_A, 1'b1, 1,  1'b0);
    vecs[2] = mk(0, 1'b1, 1'b1, 32'h1234_5600, PAT_B,  2, 1'b0, PAT_C, 1'b1, 2,  1'b0);
    vecs[3] = mk(1, 1'b0, 1'b0, 32'h4000_0000, '0,     2, 1'b1, PAT_A, 1'b0, 2,  1'b0);
    vecs[4] = mk(0, 1'b0, 1'b0, 32'h0000_0100, '0,     0, 1'b1, PAT_B, 1'b0, TO, 1'b1);
    vecs[5] = mk(1, 1'b0, 1'b0, 32'h0000_0200, '0,     3, 1'b0, PAT_B, 1'b0, 3,  1'b0);
    vecs[6] = mk(0, 1'b1, 1'b0, 32'h0000_0300, PAT_C,  5, 1'b1, PAT_A, 1'b1, 5,  1'b0);

    rst       = 1'b0;
    req_read  = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    chk("reset_read", LW'(read), '0);
    chk("reset_write", LW'(write), '0);
    chk("reset_done", LW'(done), '0);
    chk("reset_rsp_hit", LW'(rsp_hit), '0);
    chk("reset_rsp_err", LW'(rsp_err), '0);
    chk("reset_timeout_flag", LW'(timeout_flag), '0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_hit_count", LW'(hit_count), '0);
    chk("reset_miss_count", LW'(miss_count), '0);
    chk("reset_load_address", LW'(load_address), '0);
    chk("reset_write_address", LW'(write_address), '0);
    chk("reset_write_data", write_data, '0);

    // Both ports read at once after reset: port 0 first, one-cycle strobe gap.
    cfg_lat = 1; cfg_hit = 1'b0; cfg_load = PAT_A;
    push_exp(0, 1'b0, 1'b0, 1'b0, PAT_A);
    push_exp(1, 1'b0, 1'b0, 1'b0, PAT_A);
    req_addr[0] = 32'h0000_0000;
    req_addr[1] = 32'h4000_0000;
    req_read    = 2'b11;
    wait_done(0, 1'b0, 20, cyc);
    wait_done(1, 1'b0, 20, cyc);
    chk("tie_gap", LW'(last_gap), LW'(1));
    chk("tie_port1_addr", LW'(run_addr), LW'(32'h4000_0000));
    chk("tie_load_address", LW'(load_address), LW'(32'h4000_0000));
    $display("tie sequence: gap %0d port1 addr %0h", last_gap, run_addr);
    @(negedge clk);

    // Port 0 held continuously with port 1 also requesting: 0,1,0,1.
    cfg_lat = 2; cfg_hit = 1'b1; cfg_load = PAT_B;
    for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0, 1'b0, 1'b1, PAT_B);
    req_addr[0] = 32'h0000_0010;
    req_addr[1] = 32'h0000_0020;
    req_read    = 2'b11;
    wait_done(0, 1'b1, 20, cyc);
    wait_done(1, 1'b1, 20, cyc);
    wait_done(0, 1'b1, 20, cyc);
    wait_done(1, 1'b0, 20, cyc);
    req_read[0] = 1'b0;
    chk("alt_gap", LW'(last_gap), LW'(1));
    $display("alternation sequence: gap %0d", last_gap);
    @(negedge clk);

    // Table-driven single transactions.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      cfg_lat = v.lat; cfg_hit = v.hitv; cfg_load = v.load;
      push_exp(v.port, v.exp_wr, v.exp_err, v.hitv, v.load);
      req_addr[v.port]  = v.addr;
      req_wdata[v.port] = v.wdata;
      req_write[v.port] = v.wr | v.both;
      req_read[v.port]  = ~v.wr | v.both;
      wait_done(v.port, 1'b0, 40, cyc);
      chk("req_to_done", LW'(cyc), LW'(v.exp_strobe + 1));
      @(negedge clk);
      chk("strobe_len", LW'(last_run), LW'(v.exp_strobe));
      chk("cache_addr", LW'(run_addr), LW'(v.addr));
      chk("strobe_is_write", LW'(run_wr), LW'(v.exp_wr));
      if (v.exp_wr) chk("cache_wdata", run_wdata, v.wdata);
      chk("strobe_stable", LW'(unstable), '0);
      chk("write_address", LW'(write_address), LW'(v.addr));
      $display("vector %0d port %0d wr %0d strobe %0d cycles %0d", i, v.port, run_wr, last_run, cyc);
    end

    // Reset in the middle of ISSUE drops strobes at once, no done.
    cfg_lat = 0;
    req_addr[0] = 32'h0000_0500;
    req_read[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("strobe_before_reset", LW'(read), LW'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_reset_read", LW'(read), '0);
    chk("async_reset_write", LW'(write), '0);
    chk("async_reset_done", LW'(done), '0);
    chk("async_reset_hit_count", LW'(hit_count), '0);
    chk("async_reset_timeout_flag", LW'(timeout_flag), '0);
    $display("mid-issue reset: read %0d write %0d done %0d", read, write, done);
    req_read = 2'b00;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Recovery; request changed and dropped right after grant.
    cfg_lat = 2; cfg_hit = 1'b0; cfg_load = PAT_C;
    push_exp(1, 1'b0, 1'b0, 1'b0, PAT_C);
    req_addr[1] = 32'h4000_0040;
    req_read[1] = 1'b1;
    @(negedge clk);
    req_addr[1] = 32'hDEAD_BEEF;
    req_read[1] = 1'b0;
    wait_done(1, 1'b0, 20, cyc);
    @(negedge clk);
    chk("recover_addr", LW'(run_addr), LW'(32'h4000_0040));
    chk("recover_strobe_len", LW'(last_run), LW'(2));
    chk("recover_load_address", LW'(load_address), LW'(32'h4000_0040));
    $display("recovery: addr %0h strobe %0d", run_addr, last_run);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", LW'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
